// File: rtl/cpu_param.sv
// Parametrised multicycle CPU core: one shared instruction/data memory port with
// wait-request handshake, eight general registers, N/Z flags, HALT state and debug outputs.
module cpu_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_rddata,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic              i_mem_wait,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_pc
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_LDWB   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_MVHI = 4'd6;
    localparam logic [3:0] OP_J    = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_JN   = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [15:0]        ir_q, ir_d;
    logic               n_q, n_d;
    logic               z_q, z_d;
    logic [DATA_W-1:0]  regs_q [8];
    logic [DATA_W-1:0]  regs_d [8];

    // Instruction fields of the latched word
    logic [3:0]         opcode;
    logic               imm_f;
    logic [2:0]         rx_idx;
    logic [2:0]         ry_idx;
    logic [DATA_W-1:0]  imm8_sext;
    logic [ADDR_W-1:0]  imm11_sext;

    assign opcode     = ir_q[3:0];
    assign imm_f      = ir_q[4];
    assign rx_idx     = ir_q[7:5];
    assign ry_idx     = ir_q[10:8];
    assign imm8_sext  = DATA_W'($signed(ir_q[15:8]));
    assign imm11_sext = ADDR_W'($signed(ir_q[15:5]));

    logic [DATA_W-1:0]  rx_val;
    logic [DATA_W-1:0]  ry_val;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  sum_val;
    logic [DATA_W-1:0]  diff_val;
    logic [DATA_W-1:0]  mvhi_val;
    logic [ADDR_W-1:0]  jump_target;
    logic               jump_taken;
    logic               is_mem_op;

    assign rx_val      = regs_q[rx_idx];
    assign ry_val      = regs_q[ry_idx];
    assign op_b        = imm_f ? imm8_sext : ry_val;
    assign sum_val     = rx_val + op_b;
    assign diff_val    = rx_val - op_b;
    assign jump_target = imm_f ? (pc_q + imm11_sext) : rx_val[ADDR_W-1:0];
    assign is_mem_op   = (opcode == OP_LD) || (opcode == OP_ST);

    always_comb begin
        mvhi_val        = rx_val;
        mvhi_val[15:8]  = ir_q[15:8];
    end

    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            OP_J, OP_CALL: jump_taken = 1'b1;
            OP_JZ:         jump_taken = z_q;
            OP_JN:         jump_taken = n_q;
            default:       jump_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (!i_mem_wait) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LD:   state_d = i_mem_wait ? S_EXEC : S_LDWB;
                    OP_ST:   state_d = i_mem_wait ? S_EXEC : S_FETCH;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_LDWB:  state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs; gating with the reset input keeps requests low the instant reset asserts
    always_comb begin
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = pc_q;
        o_mem_wrdata = rx_val;
        o_halted     = (state_q == S_HALT);
        o_pc         = pc_q;
        case (state_q)
            S_FETCH: o_mem_rd = reset;
            S_EXEC: begin
                if (is_mem_op) begin
                    o_mem_addr = ry_val[ADDR_W-1:0];
                end
                o_mem_rd = reset && (opcode == OP_LD);
                o_mem_wr = reset && (opcode == OP_ST);
            end
            default: begin
                o_mem_rd = 1'b0;
                o_mem_wr = 1'b0;
            end
        endcase
    end

    // Datapath updates: decode latch, register writes, flags and PC
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        n_d  = n_q;
        z_d  = z_q;
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        case (state_q)
            S_DECODE: begin
                ir_d = i_mem_rddata[15:0];
                pc_d = pc_q + ADDR_W'(1);
            end
            S_EXEC: begin
                case (opcode)
                    OP_MV:   regs_d[rx_idx] = op_b;
                    OP_ADD: begin
                        regs_d[rx_idx] = sum_val;
                        n_d = sum_val[DATA_W-1];
                        z_d = (sum_val == '0);
                    end
                    OP_SUB: begin
                        regs_d[rx_idx] = diff_val;
                        n_d = diff_val[DATA_W-1];
                        z_d = (diff_val == '0);
                    end
                    OP_CMP: begin
                        n_d = diff_val[DATA_W-1];
                        z_d = (diff_val == '0);
                    end
                    OP_MVHI: regs_d[rx_idx] = mvhi_val;
                    OP_CALL: begin
                        // Target was read from the old R7, so "call R7" jumps before the link lands
                        regs_d[7] = DATA_W'(pc_q);
                        pc_d      = jump_target;
                    end
                    OP_J, OP_JZ, OP_JN: begin
                        if (jump_taken) begin
                            pc_d = jump_target;
                        end
                    end
                    default: ;
                endcase
            end
            S_LDWB: regs_d[rx_idx] = i_mem_rddata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            ir_q <= '0;
            n_q  <= 1'b0;
            z_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            n_q  <= n_d;
            z_q  <= z_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_regfile
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                regs_q[gi] <= '0;
            end else begin
                regs_q[gi] <= regs_d[gi];
            end
        end
    end

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: a 16/16 core with a wait-injecting memory model and a
// 32/12 core with a zero-wait memory, driven by small hand-assembled programs.
module tb_cpu_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: DATA_W=16, ADDR_W=16 ----------------
    logic        reset_a = 1'b0;
    logic [15:0] a_addr, a_wrdata, a_pc;
    logic [15:0] a_rddata = 16'hDEAD;
    logic        a_rd, a_wr, a_wait, a_halted;
    logic        wait_en = 1'b0;
    logic        hold_wr = 1'b0;
    int          stall_cnt = 0;
    logic [15:0] mem_a [256];

    cpu_param #(.DATA_W(16), .ADDR_W(16)) dut_a (
        .clk(clk), .reset(reset_a),
        .o_mem_addr(a_addr), .o_mem_rd(a_rd), .i_mem_rddata(a_rddata),
        .o_mem_wr(a_wr), .o_mem_wrdata(a_wrdata), .i_mem_wait(a_wait),
        .o_halted(a_halted), .o_pc(a_pc)
    );

    assign a_wait = (wait_en && (a_rd || a_wr) && (stall_cnt < 3)) || (hold_wr && a_wr);

    always @(posedge clk) begin
        if (!reset_a) stall_cnt <= 0;
        else if ((a_rd || a_wr) && !a_wait) stall_cnt <= 0;
        else if (a_rd || a_wr) stall_cnt <= stall_cnt + 1;
    end

    logic [15:0] rda_addr [256];
    int          rda_t [256];
    int          rda_n = 0;
    logic [15:0] wra_addr [256];
    logic [15:0] wra_data [256];
    int          wra_n = 0;

    always @(posedge clk) begin
        if (a_rd && !a_wait) begin
            a_rddata <= mem_a[a_addr[7:0]];
            if (rda_n < 256) begin
                rda_addr[rda_n] <= a_addr;
                rda_t[rda_n]    <= cyc;
                rda_n           <= rda_n + 1;
            end
        end else begin
            a_rddata <= 16'hDEAD;
        end
        if (a_wr && !a_wait && wra_n < 256) begin
            wra_addr[wra_n] <= a_addr;
            wra_data[wra_n] <= a_wrdata;
            wra_n           <= wra_n + 1;
            $display("write A addr=%h data=%h cycle=%0d", a_addr, a_wrdata, cyc);
        end
    end

    // Request-stability monitor: a held request must not change, rd/wr never together
    logic        pend_q = 1'b0;
    logic        p_rd, p_wr;
    logic [15:0] p_addr, p_wrdata;
    int          stab_err = 0;
    always @(posedge clk) begin
        if (!reset_a) begin
            pend_q <= 1'b0;
        end else begin
            if ((a_rd && a_wr) ||
                (pend_q && (a_rd !== p_rd || a_wr !== p_wr || a_addr !== p_addr ||
                            (a_wr && a_wrdata !== p_wrdata))))
                stab_err <= stab_err + 1;
            pend_q   <= (a_rd || a_wr) && a_wait;
            p_rd     <= a_rd;
            p_wr     <= a_wr;
            p_addr   <= a_addr;
            p_wrdata <= a_wrdata;
        end
    end

    // ---------------- DUT B: DATA_W=32, ADDR_W=12 ----------------
    logic        reset_b = 1'b0;
    logic [11:0] b_addr, b_pc;
    logic [31:0] b_wrdata;
    logic [31:0] b_rddata = 32'hDEADBEEF;
    logic        b_rd, b_wr, b_halted;
    logic        b_wait = 1'b0;
    logic [31:0] mem_b [4096];

    cpu_param #(.DATA_W(32), .ADDR_W(12)) dut_b (
        .clk(clk), .reset(reset_b),
        .o_mem_addr(b_addr), .o_mem_rd(b_rd), .i_mem_rddata(b_rddata),
        .o_mem_wr(b_wr), .o_mem_wrdata(b_wrdata), .i_mem_wait(b_wait),
        .o_halted(b_halted), .o_pc(b_pc)
    );

    logic [11:0] rdb_addr [256];
    int          rdb_n = 0;
    logic [11:0] wrb_addr [256];
    logic [31:0] wrb_data [256];
    int          wrb_n = 0;

    always @(posedge clk) begin
        if (b_rd && !b_wait) begin
            b_rddata <= mem_b[b_addr];
            if (rdb_n < 256) begin
                rdb_addr[rdb_n] <= b_addr;
                rdb_n           <= rdb_n + 1;
            end
        end else begin
            b_rddata <= 32'hDEADBEEF;
        end
        if (b_wr && !b_wait && wrb_n < 256) begin
            wrb_addr[wrb_n] <= b_addr;
            wrb_data[wrb_n] <= b_wrdata;
            wrb_n           <= wrb_n + 1;
            $display("write B addr=%h data=%h cycle=%0d", b_addr, b_wrdata, cyc);
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] f_ri(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] imm);
        return {imm, rx, 1'b1, op};
    endfunction
    function automatic logic [15:0] f_rr(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {5'b0, ry, rx, 1'b0, op};
    endfunction
    function automatic logic [15:0] f_j(input logic [3:0] op, input logic [10:0] imm);
        return {imm, 1'b1, op};
    endfunction

    task automatic enter_reset_a();
        @(negedge clk);
        reset_a = 1'b0;
        for (int i = 0; i < 256; i++) mem_a[i] = 16'h000F;
    endtask

    task automatic run_a(input int max, output int n);
        n = 0;
        while (!a_halted && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem_a[i] = 16'h000F;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", a_rd); end
        checks++; if (a_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", a_wr); end
        checks++; if (a_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", a_halted); end
        checks++; if (a_pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", a_pc); end
        checks++; if (a_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", a_addr); end
        checks++; if (b_rd !== 1'b0 || b_halted !== 1'b0) begin errors++; $display("FAIL reset_b rd=%b halted=%b want 0 0", b_rd, b_halted); end
        reset_a = 1'b1;
        #1;
        checks++; if (a_rd !== 1'b1 || a_addr !== 16'h0) begin errors++; $display("FAIL first_fetch rd=%b addr=%h want 1 0000", a_rd, a_addr); end
        $display("test_reset done");
    endtask

    task automatic test_alu_flow();
        int n, base;
        enter_reset_a();
        mem_a[0] = f_ri(4'd0, 3'd1, 8'h05);
        mem_a[1] = f_ri(4'd1, 3'd1, 8'hFB);
        mem_a[2] = f_j(4'd9, 11'd1);
        base = rda_n;
        @(negedge clk);
        reset_a = 1'b1;
        run_a(100, n);
        checks++; if (n !== 12) begin errors++; $display("FAIL alu_cycles got %0d want 12", n); end
        checks++; if (a_halted !== 1'b1 || a_pc !== 16'd5) begin errors++; $display("FAIL alu_halt halted=%b pc=%h want 1 0005", a_halted, a_pc); end
        checks++; if (rda_n - base !== 4 || rda_addr[base+2] !== 16'd2 || rda_addr[base+3] !== 16'd4)
            begin errors++; $display("FAIL alu_fetch_seq count=%0d third=%h fourth=%h want 4 0002 0004", rda_n - base, rda_addr[base+2], rda_addr[base+3]); end
        checks++; if (rda_t[base+1] - rda_t[base] !== 3) begin errors++; $display("FAIL alu_cpi got %0d want 3", rda_t[base+1] - rda_t[base]); end
        @(negedge clk);
        checks++; if (a_rd !== 1'b0 || a_wr !== 1'b0) begin errors++; $display("FAIL halt_quiet rd=%b wr=%b want 0 0", a_rd, a_wr); end
        $display("test_alu_flow cycles=%0d pc=%h", n, a_pc);
    endtask

    task automatic test_mvhi();
        int n, wbase;
        enter_reset_a();
        mem_a[0] = f_ri(4'd0, 3'd3, 8'h20);
        mem_a[1] = f_ri(4'd0, 3'd2, 8'h34);
        mem_a[2] = f_ri(4'd6, 3'd2, 8'h12);
        mem_a[3] = f_rr(4'd5, 3'd2, 3'd3);
        wbase = wra_n;
        @(negedge clk);
        reset_a = 1'b1;
        run_a(100, n);
        checks++; if (n !== 15) begin errors++; $display("FAIL mvhi_cycles got %0d want 15", n); end
        checks++; if (wra_n - wbase !== 1) begin errors++; $display("FAIL mvhi_wr_count got %0d want 1", wra_n - wbase); end
        checks++; if (wra_addr[wbase] !== 16'h0020 || wra_data[wbase] !== 16'h1234)
            begin errors++; $display("FAIL mvhi_write addr=%h data=%h want 0020 1234", wra_addr[wbase], wra_data[wbase]); end
        $display("test_mvhi cycles=%0d", n);
    endtask

    task automatic test_wait_stretch();
        int n, base, wbase, serr0;
        enter_reset_a();
        mem_a[0]    = f_ri(4'd0, 3'd4, 8'h40);
        mem_a[1]    = f_rr(4'd4, 3'd5, 3'd4);
        mem_a[2]    = f_ri(4'd0, 3'd6, 8'h41);
        mem_a[3]    = f_rr(4'd5, 3'd5, 3'd6);
        mem_a[8'h40] = 16'hBEEF;
        wait_en = 1'b1;
        base  = rda_n;
        wbase = wra_n;
        serr0 = stab_err;
        @(negedge clk);
        reset_a = 1'b1;
        run_a(200, n);
        wait_en = 1'b0;
        checks++; if (n !== 37) begin errors++; $display("FAIL wait_total got %0d want 37", n); end
        checks++; if (rda_t[base+1] - rda_t[base] !== 6) begin errors++; $display("FAIL wait_mvi got %0d want 6", rda_t[base+1] - rda_t[base]); end
        checks++; if (rda_t[base+3] - rda_t[base+1] !== 10) begin errors++; $display("FAIL wait_ld got %0d want 10", rda_t[base+3] - rda_t[base+1]); end
        checks++; if (rda_addr[base+2] !== 16'h0040) begin errors++; $display("FAIL wait_ld_addr got %h want 0040", rda_addr[base+2]); end
        checks++; if (wra_addr[wbase] !== 16'h0041 || wra_data[wbase] !== 16'hBEEF)
            begin errors++; $display("FAIL wait_ld_data addr=%h data=%h want 0041 beef", wra_addr[wbase], wra_data[wbase]); end
        checks++; if (stab_err - serr0 !== 0) begin errors++; $display("FAIL wait_stable got %0d violations want 0", stab_err - serr0); end
        $display("test_wait_stretch cycles=%0d", n);
    endtask

    task automatic test_call_return();
        int n, base, wbase;
        logic [15:0] exp_seq [5];
        exp_seq[0] = 16'd0; exp_seq[1] = 16'd10; exp_seq[2] = 16'd14; exp_seq[3] = 16'd11; exp_seq[4] = 16'd12;
        enter_reset_a();
        mem_a[0]  = f_j(4'd8, 11'd9);
        mem_a[10] = f_j(4'd12, 11'd3);
        mem_a[11] = f_rr(4'd5, 3'd7, 3'd0);
        mem_a[14] = f_rr(4'd8, 3'd7, 3'd0);
        base  = rda_n;
        wbase = wra_n;
        @(negedge clk);
        reset_a = 1'b1;
        run_a(100, n);
        checks++; if (rda_n - base !== 5) begin errors++; $display("FAIL call_fetch_count got %0d want 5", rda_n - base); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rda_addr[base+k] !== exp_seq[k]) begin errors++; $display("FAIL call_fetch%0d got %h want %h", k, rda_addr[base+k], exp_seq[k]); end
        end
        checks++; if (wra_addr[wbase] !== 16'h0000 || wra_data[wbase] !== 16'd11)
            begin errors++; $display("FAIL call_link addr=%h data=%h want 0000 000b", wra_addr[wbase], wra_data[wbase]); end
        $display("test_call_return cycles=%0d", n);
    endtask

    task automatic test_width();
        int n, base, wbase;
        logic [11:0] exp_seq [10];
        exp_seq[0] = 12'h000; exp_seq[1] = 12'h001; exp_seq[2] = 12'h002; exp_seq[3] = 12'h004; exp_seq[4] = 12'h005;
        exp_seq[5] = 12'h006; exp_seq[6] = 12'h008; exp_seq[7] = 12'h009; exp_seq[8] = 12'hFFF; exp_seq[9] = 12'h000;
        for (int i = 0; i < 4096; i++) mem_b[i] = 32'h0000000F;
        mem_b[0]      = {16'h0, f_ri(4'd0, 3'd1, 8'hFF)};
        mem_b[1]      = {16'h0, f_ri(4'd1, 3'd1, 8'h01)};
        mem_b[2]      = {16'h0, f_j(4'd9, 11'd1)};
        mem_b[4]      = {16'h0, f_j(4'd10, 11'd1)};
        mem_b[5]      = {16'h0, f_ri(4'd2, 3'd1, 8'h01)};
        mem_b[6]      = {16'h0, f_j(4'd10, 11'd1)};
        mem_b[8]      = {16'h0, f_rr(4'd5, 3'd1, 3'd0)};
        mem_b[9]      = {16'h0, f_j(4'd8, 11'h7F5)};
        mem_b[12'hFFF] = {16'h0, f_ri(4'd0, 3'd3, 8'h01)};
        base  = rdb_n;
        wbase = wrb_n;
        @(negedge clk);
        reset_b = 1'b1;
        n = 0;
        while (rdb_n - base < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset_b = 1'b0;
        checks++; if (rdb_n - base < 10) begin errors++; $display("FAIL width_fetch_count got %0d want 10", rdb_n - base); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rdb_addr[base+k] !== exp_seq[k]) begin errors++; $display("FAIL width_fetch%0d got %h want %h", k, rdb_addr[base+k], exp_seq[k]); end
        end
        checks++; if (wrb_n - wbase !== 1 || wrb_addr[wbase] !== 12'h000 || wrb_data[wbase] !== 32'hFFFFFFFF)
            begin errors++; $display("FAIL width_store count=%0d addr=%h data=%h want 1 000 ffffffff", wrb_n - wbase, wrb_addr[wbase], wrb_data[wbase]); end
        $display("test_width cycles=%0d", n);
    endtask

    task automatic test_reset_mid_store();
        int n, wbase;
        enter_reset_a();
        mem_a[0] = f_ri(4'd0, 3'd1, 8'h55);
        mem_a[1] = f_ri(4'd0, 3'd2, 8'h30);
        mem_a[2] = f_rr(4'd5, 3'd1, 3'd2);
        hold_wr = 1'b1;
        wbase = wra_n;
        @(negedge clk);
        reset_a = 1'b1;
        n = 0;
        while (a_wr !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (a_wr !== 1'b1) begin errors++; $display("FAIL rst_store_reached wr=%b want 1", a_wr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_wr !== 1'b1 || a_addr !== 16'h0030 || a_wrdata !== 16'h0055)
            begin errors++; $display("FAIL rst_store_held wr=%b addr=%h data=%h want 1 0030 0055", a_wr, a_addr, a_wrdata); end
        @(posedge clk);
        #2;
        reset_a = 1'b0;
        #1;
        checks++; if (a_wr !== 1'b0 || a_rd !== 1'b0) begin errors++; $display("FAIL rst_async_drop wr=%b rd=%b want 0 0", a_wr, a_rd); end
        checks++; if (a_pc !== 16'h0 || a_addr !== 16'h0 || a_halted !== 1'b0)
            begin errors++; $display("FAIL rst_async_state pc=%h addr=%h halted=%b want 0000 0000 0", a_pc, a_addr, a_halted); end
        checks++; if (wra_n - wbase !== 0) begin errors++; $display("FAIL rst_no_write got %0d writes want 0", wra_n - wbase); end
        hold_wr = 1'b0;
        for (int i = 0; i < 256; i++) mem_a[i] = 16'h000F;
        mem_a[0] = f_rr(4'd5, 3'd1, 3'd2);
        @(negedge clk);
        reset_a = 1'b1;
        #1;
        checks++; if (a_rd !== 1'b1 || a_addr !== 16'h0) begin errors++; $display("FAIL rst_restart rd=%b addr=%h want 1 0000", a_rd, a_addr); end
        run_a(100, n);
        checks++; if (n !== 6) begin errors++; $display("FAIL rst_cycles got %0d want 6", n); end
        checks++; if (wra_n - wbase !== 1 || wra_addr[wbase] !== 16'h0000 || wra_data[wbase] !== 16'h0000)
            begin errors++; $display("FAIL rst_regs_cleared count=%0d addr=%h data=%h want 1 0000 0000", wra_n - wbase, wra_addr[wbase], wra_data[wbase]); end
        $display("test_reset_mid_store cycles=%0d", n);
    endtask

    initial begin
        test_reset();
        test_alu_flow();
        test_mvhi();
        test_wait_stretch();
        test_call_return();
        test_width();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
